// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: default geometry and occupancy-counter width helper shared by dff_pipe and dff_stage
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH = 8;
    localparam int DFF_PIPE_DEPTH = 4;

    // Bits needed to count 0..depth items inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipe slot, a valid bit plus a data register with load enable
//   clk, rst   : clock, asynchronous active-high reset (v=0, d=RESET_VAL)
//   flush      : empty the slot at the next edge, data untouched
//   load       : capture din and become valid
//   take       : the held item moves on this edge
//   din        : incoming data
//   v, d       : slot valid and data
module dff_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // A slot that is both taken and reloaded stays valid with the new item.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            v <= !flush && (load || (v && !take));
            if (load && !flush)
                d <= din;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid/ready register pipe with bubble collapse and flush
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_data captured on in_valid && in_ready
//   out_valid/out_ready   : downstream handshake, out_data is the last-stage register
//   flush                 : discard every held item at the next edge
//   occ                   : held-item count, only with DFF_PIPE_OCC_EN defined
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_WIDTH,
    parameter int               DEPTH     = DFF_PIPE_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]   occ
`endif
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            take;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] din;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // Stage g can move iff the sink drains or any slot from g onward is empty;
        // the flat form avoids a combinational chain through one vector.
        assign adv[g] = out_ready || !(&v[DEPTH-1:g]);
        if (g == 0) begin : g_head
            assign load[g] = in_valid && in_ready;
            assign din[g]  = in_data;
        end else begin : g_body
            assign load[g] = v[g-1] && adv[g];
            assign din[g]  = d[g-1];
        end
        if (g == DEPTH - 1) begin : g_tail
            assign take[g] = out_ready;
        end else begin : g_mid
            assign take[g] = adv[g+1];
        end
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (load[g]),
            .take  (take[g]),
            .din   (din[g]),
            .v     (v[g]),
            .d     (d[g])
        );
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);
    logic in_fire;
    logic out_fire;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occ <= '0;
        else
            occ <= flush ? '0 : occ + OW'(in_fire) - OW'(out_fire);
    end
`endif

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream data valid.
REQ-007 SHALL have port in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream data.
REQ-009 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage data register.
REQ-012 SHALL have port flush  input  1  synchronous discard of all held items.
REQ-013 SHALL have port occ  output  clog2(DEPTH+1)  item count, present only under DFF_PIPE_OCC_EN.

Function
REQ-014 SHALL hold per stage i a valid bit v[i] and WIDTH-bit data register d[i]; stage DEPTH-1 drives out_valid/out_data.
REQ-015 SHALL define adv[DEPTH-1] = !v[DEPTH-1] || out_ready; adv[i] = !v[i] || adv[i+1]; in_ready = adv[0] && !flush.
REQ-016 SHALL load stage i+1 from stage i when v[i] && adv[i+1]; stage 0 loads in_data when in_valid && in_ready.
REQ-017 SHALL collapse bubbles: an item advances every cycle the next stage is empty or advancing, regardless of out_ready further back.
REQ-018 SHALL update d[i] only on load; held or empty stages keep their data value unchanged.
REQ-019 SHALL present an item accepted at the edge ending cycle N on out_valid in cycle N+DEPTH when the pipe is empty and out_ready stays high.
REQ-020 SHALL sustain one transfer per cycle when out_ready is held high; capacity is exactly DEPTH items.
REQ-021 SHALL, at full with out_ready=1 and in_valid=1, accept and emit in the same cycle (in_ready=1 combinationally from out_ready).
REQ-022 SHALL preserve strict FIFO order; no item is dropped or duplicated except by flush or rst.
REQ-023 SHALL, on flush=1, clear all v[i] at the next edge, accept no input that cycle, and leave d[i] unchanged; flush outranks out_ready and in_valid.

Reset
REQ-024 SHALL on rst=1 immediately (asynchronously) clear all v[i], set all d[i]=RESET_VAL, giving out_valid=0, out_data=RESET_VAL, in_ready=1 (flush=0).
REQ-025 SHALL discard all in-flight items on rst mid-operation; first edge after rst deasserts behaves as an empty pipe.

Configuration
REQ-026 SHALL, with DFF_PIPE_OCC_EN defined, provide occ: +1 on input accept, -1 on output accept, unchanged on both, 0 on flush or rst.
REQ-027 SHALL, without DFF_PIPE_OCC_EN, omit the occ port and counter; all other behaviour is identical.

Structure
REQ-028 SHALL place default WIDTH/DEPTH constants and the occ width function in package dff_pipe_pkg.
REQ-029 SHALL build each stage from sub-module dff_stage (valid bit + data register, load enable, async active-high reset to RESET_VAL).

Verification (WIDTH=8, DEPTH=4)
REQ-030 SHALL test reset: assert rst between edges mid-stream -> out_valid=0, out_data=0x00, in_ready=1 before next edge; occ=0.
REQ-031 SHALL test streaming: push 0x01..0x08 back-to-back, out_ready=1 -> first out_valid 4 cycles after first accept, 8 consecutive beats in order.
REQ-032 SHALL test backpressure: out_ready=0, push until in_ready=0 -> exactly 4 accepted, occ=4; then out_ready=1, in_valid=1 one cycle -> 0x01 out, new item in, occ stays 4.
REQ-033 SHALL test bubble collapse: out_ready=0, push 0xA0, idle 2 cycles, push 0xB0 -> after settling v=1 at stages 3 and 2, d[3]=0xA0, d[2]=0xB0.
REQ-034 SHALL test flush: 3 items held, flush=1 with in_valid=1 -> in_ready=0 that cycle, next cycle out_valid=0, occ=0, nothing emitted later.
